// File: rtl/dmem_if.sv
// Request/response channel between a memory initiator and a memory responder.
// The master drives requests and accepts responses; the slave does the opposite.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        req_wen;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_resp.sv
// Single-outstanding memory responder: 64-bit word array with byte-enabled writes,
// programmable response latency and out-of-range error reporting.
module dmem_resp #(
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  dmem_if.slave       bus,
  output logic [63:0] nr_reqs_o
);

  localparam int          IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [63:0] SPAN     = 64'(DEPTH_WORDS) << 3;
  localparam logic [3:0]  LAT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic [63:0] nr_q, nr_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [63:0] mem_q [DEPTH_WORDS];

  logic             accept_s;
  logic             mem_we_s;
  logic [63:0]      cur_addr_s;
  logic             cur_wen_s;
  logic [63:0]      cur_wdata_s;
  logic [7:0]       cur_wstrb_s;
  logic [63:0]      off_s;
  logic             oor_s;
  logic [IDX_W-1:0] idx_s;

  assign bus.req_ready  = (state_q == ST_IDLE) && !reset;
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign nr_reqs_o      = nr_q;
  assign accept_s       = bus.req_valid && bus.req_ready;

  // With zero latency the array is accessed on the accepting edge, so the
  // access path looks straight at the bus while idle.
  assign cur_addr_s  = (state_q == ST_IDLE) ? bus.req_addr  : addr_q;
  assign cur_wen_s   = (state_q == ST_IDLE) ? bus.req_wen   : wen_q;
  assign cur_wdata_s = (state_q == ST_IDLE) ? bus.req_wdata : wdata_q;
  assign cur_wstrb_s = (state_q == ST_IDLE) ? bus.req_wstrb : wstrb_q;
  assign off_s       = cur_addr_s - BASE_ADDR;
  assign oor_s       = (cur_addr_s < BASE_ADDR) || (off_s >= SPAN);
  assign idx_s       = off_s[IDX_W+2:3];

  // State and transaction registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 64'd0;
      wen_q   <= 1'b0;
      wdata_q <= 64'd0;
      wstrb_q <= 8'd0;
      nr_q    <= 64'd0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      nr_q    <= nr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; array access happens on the edge that enters RESP.
  always_comb begin
    logic enter_s;
    enter_s  = 1'b0;
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wen_d    = wen_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    nr_d     = nr_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    mem_we_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          addr_d  = bus.req_addr;
          wen_d   = bus.req_wen;
          wdata_d = bus.req_wdata;
          wstrb_d = bus.req_wstrb;
          nr_d    = nr_q + 64'd1;
          if (LATENCY > 0) begin
            state_d = ST_WAIT;
            cnt_d   = LAT_INIT;
          end else begin
            enter_s = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          enter_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          state_d = ST_IDLE;
          rdata_d = 64'd0;
          err_d   = 1'b0;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (enter_s) begin
      state_d  = ST_RESP;
      err_d    = oor_s;
      rdata_d  = oor_s ? 64'd0 : mem_q[idx_s];
      mem_we_s = cur_wen_s && !oor_s;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Byte-enabled array write; contents survive reset.
  always_ff @(posedge clock) begin
    for (int b = 0; b < 8; b++) begin
      if (mem_we_s && cur_wstrb_s[b]) begin
        mem_q[idx_s][8*b +: 8] <= cur_wdata_s[8*b +: 8];
      end
    end
  end

endmodule
